// File: rtl/block_c_req_ack_responder.sv
//============================================================================
// Module  : block_c_req_ack_responder
// Brief   : req/ack responder executing READ/WRITE/ADD on a register file
//           with fixed latency, busy status and saturating ack counter.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module block_c_req_ack_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ack,
    output logic [DATA_W-1:0] ack_rdata,
    output logic              ack_err,
    output logic              busy,
    output logic [15:0]       txn_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [1:0]      c_op_read  = 2'b00;
    localparam logic [1:0]      c_op_write = 2'b01;
    localparam logic [1:0]      c_op_rsvd  = 2'b11;
    localparam logic [3:0]      c_lat_m1   = 4'(LATENCY - 1);
    localparam bit              c_lat1     = (LATENCY == 1);
    localparam logic [ADDR_W:0] c_depth    = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [1:0]          w_op;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_err;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_enter_ack;

    // With LATENCY=1 the capture edge is also the execute edge, so operands come straight from the inputs.
    assign w_op    = (r_state == S_IDLE) ? req_op    : r_op;
    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_err   = (w_op == c_op_rsvd) || ({1'b0, w_addr} >= c_depth);
    assign w_old   = w_err ? '0 : r_mem[w_addr];
    assign w_sum   = w_old + w_wdata;
    assign w_rdata = w_err ? '0 :
                     ((w_op == c_op_read) || (w_op == c_op_write)) ? w_old : w_sum;

    // In BUSY the countdown hits zero on the edge where it reads 1; that same edge enters ACK.
    assign w_enter_ack = ((r_state == S_IDLE) && req && c_lat1) ||
                         ((r_state == S_BUSY) && (r_cnt <= 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            ack       <= 1'b0;
            ack_rdata <= '0;
            ack_err   <= 1'b0;
            busy      <= 1'b0;
            txn_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            ack       <= 1'b0;
            ack_rdata <= '0;
            ack_err   <= 1'b0;

            if (w_enter_ack) begin
                ack       <= 1'b1;
                ack_rdata <= w_rdata;
                ack_err   <= w_err;
                if (txn_count != 16'hFFFF) begin
                    txn_count <= txn_count + 16'd1;
                end
                if (!w_err && (w_op != c_op_read)) begin
                    r_mem[w_addr] <= (w_op == c_op_write) ? w_wdata : w_sum;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_lat_m1;
                        busy    <= 1'b1;
                        r_state <= c_lat1 ? S_ACK : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_c_req_ack_responder.sv
//============================================================================
// Module  : tb_block_c_req_ack_responder
// Brief   : scoreboard bench for three responder configurations.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_block_c_req_ack_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req       [3];
    logic [1:0]  req_op    [3];
    logic [3:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        ack       [3];
    logic [31:0] ack_rdata [3];
    logic        ack_err   [3];
    logic        busy      [3];
    logic [15:0] txn_count [3];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sbq [3][$];
    logic [31:0] mem_m [3][16];
    logic [15:0] cnt_m [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 5;
    endfunction

    function automatic int dep(input int k);
        return (k == 0) ? 12 : 16;
    endfunction

    // instance 0: DEPTH=12 LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=5
    for (genvar g = 0; g < 3; g++) begin : g_dut
        block_c_req_ack_responder #(
            .DATA_W (32),
            .ADDR_W (4),
            .DEPTH  ((g == 0) ? 12 : 16),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 5)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .req      (req[g]),
            .req_op   (req_op[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .ack      (ack[g]),
            .ack_rdata(ack_rdata[g]),
            .ack_err  (ack_err[g]),
            .busy     (busy[g]),
            .txn_count(txn_count[g])
        );
    end

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(negedge clk) begin
            exp_t e;
            if (rst_n[g] === 1'b1) begin
                if (ack[g] === 1'b1) begin
                    if (sbq[g].size() == 0) begin
                        chk("unexpected_ack", g, 32'd1, 32'd0);
                    end else begin
                        e = sbq[g].pop_front();
                        chk("ack_rdata", g, ack_rdata[g], e.rdata);
                        chk("ack_err", g, 32'(ack_err[g]), 32'(e.err));
                        chk("txn_count", g, 32'(txn_count[g]), 32'(e.cnt));
                        chk("ack_cycle", g, 32'(cyc), 32'(e.cyc));
                        chk("busy_in_ack", g, 32'(busy[g]), 32'd1);
                    end
                end else begin
                    chk("idle_outputs", g, 32'({ack_err[g], ack_rdata[g]} != 33'd0), 32'd0);
                end
            end
        end
    end

    // Reference behaviour of one request, applied in issue order.
    task automatic model(input int k, input logic [1:0] op, input logic [3:0] addr,
                         input logic [31:0] wd, output exp_t e);
        e.err   = (op == 2'b11) || (int'(addr) >= dep(k));
        e.rdata = 32'd0;
        if (!e.err) begin
            case (op)
                2'b00: e.rdata = mem_m[k][addr];
                2'b01: begin
                    e.rdata = mem_m[k][addr];
                    mem_m[k][addr] = wd;
                end
                default: begin
                    mem_m[k][addr] = mem_m[k][addr] + wd;
                    e.rdata = mem_m[k][addr];
                end
            endcase
        end
        if (cnt_m[k] != 16'hFFFF) cnt_m[k] = cnt_m[k] + 16'd1;
        e.cnt = cnt_m[k];
    endtask

    task automatic do_txn(input int k, input logic [1:0] op, input logic [3:0] addr,
                          input logic [31:0] wd, input bit violate);
        exp_t e;
        int   n;
        @(negedge clk);
        model(k, op, addr, wd, e);
        e.cyc = cyc + lat(k);
        sbq[k].push_back(e);
        req[k] = 1'b1;
        req_op[k] = op;
        req_addr[k] = addr;
        req_wdata[k] = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (violate && (ack[k] !== 1'b1)) begin
                req_op[k]    = 2'($urandom_range(0, 3));
                req_addr[k]  = 4'($urandom_range(0, 15));
                req_wdata[k] = $urandom;
            end
        end while ((ack[k] !== 1'b1) && (n < 40));
        if (ack[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack after %0d cycles", k, n);
            sbq[k].delete();
        end
        req[k] = 1'b0;
    endtask

    task automatic clear_model(input int k);
        for (int a = 0; a < 16; a++) mem_m[k][a] = 32'd0;
        cnt_m[k] = 16'd0;
        sbq[k].delete();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            req[k] = 1'b0;
            req_op[k] = 2'b00;
            req_addr[k] = 4'd0;
            req_wdata[k] = 32'd0;
            clear_model(k);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", k, 32'(ack[k]), 32'd0);
            chk("rst_rdata", k, ack_rdata[k], 32'd0);
            chk("rst_err", k, 32'(ack_err[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_count", k, 32'(txn_count[k]), 32'd0);
        end

        // Write/read, ADD wraparound, and error cases on DEPTH=12
        do_txn(0, 2'b01, 4'd3, 32'hDEADBEEF, 1'b0);
        do_txn(0, 2'b00, 4'd3, 32'h0, 1'b0);
        do_txn(0, 2'b01, 4'd5, 32'hFFFFFFF0, 1'b0);
        do_txn(0, 2'b10, 4'd5, 32'h20, 1'b0);
        do_txn(0, 2'b00, 4'd5, 32'h0, 1'b0);
        do_txn(0, 2'b01, 4'd0, 32'hA5A5A5A5, 1'b0);
        do_txn(0, 2'b00, 4'd13, 32'h0, 1'b0);
        do_txn(0, 2'b11, 4'd0, 32'h12345678, 1'b0);
        do_txn(0, 2'b00, 4'd0, 32'h0, 1'b0);
        do_txn(0, 2'b01, 4'd12, 32'h1, 1'b1);

        // Back-to-back on LATENCY=1
        for (int i = 0; i < 4; i++) do_txn(1, 2'b10, 4'(i), 32'(i + 1), 1'b0);
        @(negedge clk);
        chk("b2b_count", 1, 32'(txn_count[1]), 32'd4);

        // Reset while BUSY on LATENCY=5: the request is dropped
        @(negedge clk);
        req[2] = 1'b1;
        req_op[2] = 2'b01;
        req_addr[2] = 4'd1;
        req_wdata[2] = 32'h55;
        repeat (2) @(negedge clk);
        chk("busy_mid", 2, 32'(busy[2]), 32'd1);
        rst_n[2] = 1'b0;
        #1;
        chk("busy_after_rst", 2, 32'(busy[2]), 32'd0);
        chk("ack_after_rst", 2, 32'(ack[2]), 32'd0);
        req[2] = 1'b0;
        clear_model(2);
        repeat (4) @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        chk("count_after_rst", 2, 32'(txn_count[2]), 32'd0);
        do_txn(2, 2'b00, 4'd1, 32'h0, 1'b0);

        // Counter saturation on LATENCY=1
        @(negedge clk);
        force g_dut[1].u_dut.txn_count = 16'hFFFE;
        @(negedge clk);
        release g_dut[1].u_dut.txn_count;
        cnt_m[1] = 16'hFFFE;
        @(negedge clk);
        chk("preload_count", 1, 32'(txn_count[1]), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) do_txn(1, 2'b00, 4'd0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sat_hold", 1, 32'(txn_count[1]), 32'h0000FFFF);

        // Randomized traffic on all configurations
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                do_txn(k, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                       1'($urandom_range(0, 1)));
            end
        end

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("sb_drained", k, 32'(sbq[k].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/block_c_req_ack_responder.md
Name: block_c_req_ack_responder

Overview:
- Destination (responder) end of the req_ack interface that blockB-style sources drive toward block C.
- Accepts one request at a time and executes it against an internal register file (READ / WRITE / ADD).
- Returns a one-cycle ack carrying response data after a fixed, parameterised latency.
- Exposes busy and a saturating transaction counter for status and debug.

Parameters:
- DATA_W, 32: width of request write data and response data.
- ADDR_W, 4: request address width.
- DEPTH, 16: number of register-file entries; legal range 1..2^ADDR_W.
- LATENCY, 2: cycles from request capture to ack; legal range 1..15.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request; source holds it high, with payload stable, until it samples ack.
- req_op  in  2  opcode: 00 READ, 01 WRITE, 10 ADD, 11 reserved.
- req_addr  in  ADDR_W  register index.
- req_wdata  in  DATA_W  write data or addend.
- ack  out  1  one-cycle completion pulse.
- ack_rdata  out  DATA_W  response data; valid only while ack=1.
- ack_err  out  1  error flag; valid only while ack=1.
- busy  out  1  high in the BUSY state and the ACK state.
- txn_count  out  16  count of completed acks; saturates at 0xFFFF.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state:
  - ack=0, ack_rdata=0, ack_err=0, busy=0, txn_count=0.
  - All register-file entries are 0; FSM is in IDLE.
  - Reset asserted mid-transaction discards the pending request; no ack is ever issued for it.
- FSM states:
  - IDLE:
    - req=1 at a rising edge → capture req_op, req_addr and req_wdata; load the countdown with LATENCY-1; go to BUSY, or go directly to ACK when LATENCY=1.
    - req=0 → stay in IDLE.
  - BUSY: decrement the countdown every cycle; when it reaches 0, go to ACK on the next edge. req is ignored in this state.
  - ACK: ack=1 for exactly one cycle; always return to IDLE on the next edge.
    - req is ignored during ACK; the source drops req after sampling ack.
    - A req high in the first IDLE cycle after ACK is a new request and is accepted.
- Latency:
  - Request captured at the edge ending cycle N → ack high in cycle N+LATENCY.
  - Minimum back-to-back spacing: LATENCY+1 cycles per transaction.
- Execution, committed on the edge that enters ACK:
  - Register-file update and ack_rdata / ack_err are all registered on that same edge.
  - READ: ack_rdata = reg[addr]; no update.
  - WRITE: reg[addr] = wdata; ack_rdata = old reg[addr].
  - ADD: reg[addr] = (reg[addr] + wdata) mod 2^DATA_W; ack_rdata = new value; carry-out is discarded.
- Errors:
  - Conditions: req_op=11, or req_addr >= DEPTH.
  - Response: ack_err=1, ack_rdata=0, no register update.
  - An ack is still produced and still counted.
- Outputs outside ACK: ack_rdata and ack_err are driven to 0 whenever ack=0.
- txn_count:
  - Increments on every ack, including errored acks.
  - Holds at 0xFFFF with no wrap.
- Source protocol violation: payload changes while req is held are ignored, because the payload was already captured in IDLE.

Test Plan:
- Reset, then WRITE addr 3 wdata 0xDEADBEEF with LATENCY=2, req captured at edge N:
  - ack high in cycle N+2 only, ack_rdata=0x00000000, ack_err=0.
  - A following READ addr 3 returns 0xDEADBEEF.
- WRITE addr 5 = 0xFFFFFFF0, then ADD addr 5 wdata 0x20:
  - ack_rdata=0x00000010 (wrap); a subsequent READ returns 0x00000010.
- Errors with DEPTH=12:
  - READ addr 13 → ack_err=1, ack_rdata=0.
  - op=11 at addr 0 → ack_err=1; reg[0] is unchanged.
  - txn_count increments for both.
- Back-to-back with LATENCY=1: source re-asserts req in the cycle right after ack → accepted; acks arrive every 2 cycles; 4 requests yield txn_count=4.
- Reset mid-operation: drop rst_n while in BUSY (LATENCY=5, WRITE addr 1 = 0x55):
  - ack never asserts; busy=0 immediately; reg[1] reads 0.
- Saturation: preload or force 0xFFFE transactions, then 3 more acks → txn_count=0xFFFF and it stays there.
